pixel_stream_tagger: RTL and testbench

//  Converts the camera's AXI4-Stream RGB565 video (tuser=SOF, tlast=EOL) into the tagged

---
 rtl/led_pkg.sv | 24 ++
 rtl/pixel_stream_tagger_if.sv | 45 ++++
 rtl/pixel_stream_tagger_rgb565_unpack.sv | 20 ++
 rtl/pixel_stream_tagger.sv | 208 ++++++++++++++++++++
 tb/tb_pixel_stream_tagger.sv | 398 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/led_pkg.sv
// ---------------------------------------------------------------------------
// led_pkg : constants shared by the pixel tagger and the LED detector
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package led_pkg;
   localparam int DEF_WIDTH  = 640;
   localparam int DEF_HEIGHT = 480;
   localparam int DEF_X_W    = 12;
   localparam int DEF_Y_W    = 9;

   // RGB565 field offsets; green drops its LSB to match the 5-bit detector path
   localparam int RGB_R_LSB = 11;
   localparam int RGB_G_LSB = 6;
   localparam int RGB_B_LSB = 0;

   localparam logic [1:0] ST_WAIT_SOF = 2'd0;
   localparam logic [1:0] ST_MARK     = 2'd1;
   localparam logic [1:0] ST_STREAM   = 2'd2;
   localparam logic [1:0] ST_DROP     = 2'd3;
endpackage

`default_nettype wire

// File: rtl/pixel_stream_tagger_if.sv
// ---------------------------------------------------------------------------
// pixel_stream_tagger_if : AXI4-Stream RGB565 input and tagged pixel output
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface pixel_stream_tagger_if
   import led_pkg::*;
#(
   parameter int X_W = DEF_X_W,
   parameter int Y_W = DEF_Y_W
);
   logic           enable;
   logic [15:0]    s_tdata;
   logic           s_tvalid;
   logic           s_tuser;
   logic           s_tlast;
   logic           s_tready;
   logic           data_valid;
   logic           start_frame;
   logic           end_frame;
   logic [X_W-1:0] x;
   logic [Y_W-1:0] y;
   logic [4:0]     r;
   logic [4:0]     g;
   logic [4:0]     b;
   logic           err_short;
   logic           err_long;
   logic           err_sof;
   logic [15:0]    frame_count;

   modport master (
      output enable, s_tdata, s_tvalid, s_tuser, s_tlast,
      input  s_tready, data_valid, start_frame, end_frame, x, y, r, g, b,
             err_short, err_long, err_sof, frame_count
   );

   modport slave (
      input  enable, s_tdata, s_tvalid, s_tuser, s_tlast,
      output s_tready, data_valid, start_frame, end_frame, x, y, r, g, b,
             err_short, err_long, err_sof, frame_count
   );
endinterface

`default_nettype wire

// File: rtl/pixel_stream_tagger_rgb565_unpack.sv
// ---------------------------------------------------------------------------
// rgb565_unpack : splits an RGB565 word into three 5-bit channels
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rgb565_unpack
   import led_pkg::*;
(
   input  logic [15:0] pix,
   output logic [4:0]  r,
   output logic [4:0]  g,
   output logic [4:0]  b
);
   assign r = pix[RGB_R_LSB +: 5];
   assign g = pix[RGB_G_LSB +: 5];
   assign b = pix[RGB_B_LSB +: 5];
endmodule

`default_nettype wire

// File: rtl/pixel_stream_tagger.sv
// ---------------------------------------------------------------------------
// pixel_stream_tagger : AXI4-Stream RGB565 -> coordinate-tagged pixel beats
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pixel_stream_tagger
   import led_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int HEIGHT = DEF_HEIGHT,
   parameter int X_W    = DEF_X_W,
   parameter int Y_W    = DEF_Y_W
) (
   input  logic                 clk,
   input  logic                 reset,
   pixel_stream_tagger_if.slave bus
);
   localparam logic [X_W-1:0] X_LAST = X_W'(WIDTH - 1);
   localparam logic [Y_W-1:0] Y_LAST = Y_W'(HEIGHT - 1);

   if (WIDTH > (1 << X_W) || HEIGHT > (1 << Y_W)) begin : g_size_check
      $error("pixel_stream_tagger: WIDTH/HEIGHT exceed the X_W/Y_W counter range");
   end

   logic [1:0]     state_q, state_d;
   logic [X_W-1:0] x_cnt_q, x_cnt_d;
   logic [Y_W-1:0] y_cnt_q, y_cnt_d;
   logic [15:0]    hold_q, hold_d;
   logic           hold_last_q, hold_last_d;
   logic           s_tready_q, s_tready_d;
   logic           data_valid_q, data_valid_d;
   logic           start_frame_q, start_frame_d;
   logic           end_frame_q, end_frame_d;
   logic [X_W-1:0] x_q, x_d;
   logic [Y_W-1:0] y_q, y_d;
   logic [4:0]     r_q, r_d, g_q, g_d, b_q, b_d;
   logic           err_short_q, err_short_d;
   logic           err_long_q, err_long_d;
   logic           err_sof_q, err_sof_d;
   logic [15:0]    frame_count_q, frame_count_d;

   logic        w_accept;
   logic [15:0] w_pix;
   logic        w_last;
   logic [4:0]  w_r, w_g, w_b;
   logic        w_sof;
   logic        w_take;
   logic        w_line_end;

   assign w_accept = bus.s_tvalid & s_tready_q;

   // MARK replays the SOF beat captured in the hold register
   assign w_pix  = (state_q == ST_MARK) ? hold_q      : bus.s_tdata;
   assign w_last = (state_q == ST_MARK) ? hold_last_q : bus.s_tlast;

   rgb565_unpack u_unpack (
      .pix (w_pix),
      .r   (w_r),
      .g   (w_g),
      .b   (w_b)
   );

   always_comb begin
      state_d       = state_q;
      x_cnt_d       = x_cnt_q;
      y_cnt_d       = y_cnt_q;
      hold_d        = hold_q;
      hold_last_d   = hold_last_q;
      data_valid_d  = 1'b0;
      start_frame_d = 1'b0;
      end_frame_d   = 1'b0;
      x_d           = x_q;
      y_d           = y_q;
      r_d           = r_q;
      g_d           = g_q;
      b_d           = b_q;
      err_short_d   = 1'b0;
      err_long_d    = 1'b0;
      err_sof_d     = 1'b0;
      frame_count_d = frame_count_q;
      w_sof         = 1'b0;
      w_take        = 1'b0;
      w_line_end    = 1'b0;

      case (state_q)
         ST_WAIT_SOF: w_sof = w_accept & bus.s_tuser & bus.enable;
         ST_MARK:     w_take = 1'b1;
         default: begin
            if (w_accept && bus.s_tuser) begin
               w_sof     = 1'b1;
               err_sof_d = 1'b1;
            end else if (w_accept && state_q == ST_STREAM) begin
               w_take = 1'b1;
            end else if (w_accept && bus.s_tlast) begin
               w_line_end = 1'b1;
            end
         end
      endcase

      if (w_sof) begin
         hold_d        = bus.s_tdata;
         hold_last_d   = bus.s_tlast;
         x_cnt_d       = '0;
         y_cnt_d       = '0;
         state_d       = ST_MARK;
         data_valid_d  = 1'b1;
         start_frame_d = 1'b1;
         x_d           = '0;
         y_d           = '0;
         r_d           = '0;
         g_d           = '0;
         b_d           = '0;
      end

      if (w_take) begin
         data_valid_d = 1'b1;
         x_d          = x_cnt_q;
         y_d          = y_cnt_q;
         r_d          = w_r;
         g_d          = w_g;
         b_d          = w_b;
         x_cnt_d      = x_cnt_q + X_W'(1);
         state_d      = ST_STREAM;
         if (w_last) begin
            err_short_d = (x_cnt_q != X_LAST);
            w_line_end  = 1'b1;
         end else if (x_cnt_q == X_LAST) begin
            err_long_d = 1'b1;
            state_d    = ST_DROP;
         end
      end

      // end_frame only marks a real pixel; a frame closed from DROP just counts
      if (w_line_end) begin
         x_cnt_d = '0;
         if (y_cnt_q == Y_LAST) begin
            y_cnt_d       = '0;
            end_frame_d   = w_take;
            frame_count_d = frame_count_q + 16'd1;
            state_d       = ST_WAIT_SOF;
         end else begin
            y_cnt_d = y_cnt_q + Y_W'(1);
            state_d = ST_STREAM;
         end
      end

      s_tready_d = (state_d != ST_MARK);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_WAIT_SOF;
         x_cnt_q       <= '0;
         y_cnt_q       <= '0;
         hold_q        <= '0;
         hold_last_q   <= 1'b0;
         s_tready_q    <= 1'b1;
         data_valid_q  <= 1'b0;
         start_frame_q <= 1'b0;
         end_frame_q   <= 1'b0;
         x_q           <= '0;
         y_q           <= '0;
         r_q           <= '0;
         g_q           <= '0;
         b_q           <= '0;
         err_short_q   <= 1'b0;
         err_long_q    <= 1'b0;
         err_sof_q     <= 1'b0;
         frame_count_q <= '0;
      end else begin
         state_q       <= state_d;
         x_cnt_q       <= x_cnt_d;
         y_cnt_q       <= y_cnt_d;
         hold_q        <= hold_d;
         hold_last_q   <= hold_last_d;
         s_tready_q    <= s_tready_d;
         data_valid_q  <= data_valid_d;
         start_frame_q <= start_frame_d;
         end_frame_q   <= end_frame_d;
         x_q           <= x_d;
         y_q           <= y_d;
         r_q           <= r_d;
         g_q           <= g_d;
         b_q           <= b_d;
         err_short_q   <= err_short_d;
         err_long_q    <= err_long_d;
         err_sof_q     <= err_sof_d;
         frame_count_q <= frame_count_d;
      end
   end

   assign bus.s_tready    = s_tready_q;
   assign bus.data_valid  = data_valid_q;
   assign bus.start_frame = start_frame_q;
   assign bus.end_frame   = end_frame_q;
   assign bus.x           = x_q;
   assign bus.y           = y_q;
   assign bus.r           = r_q;
   assign bus.g           = g_q;
   assign bus.b           = b_q;
   assign bus.err_short   = err_short_q;
   assign bus.err_long    = err_long_q;
   assign bus.err_sof     = err_sof_q;
   assign bus.frame_count = frame_count_q;
endmodule

`default_nettype wire

// File: tb/tb_pixel_stream_tagger.sv
// ---------------------------------------------------------------------------
// tb_pixel_stream_tagger : directed bench for pixel_stream_tagger on a 4x3 frame
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pixel_stream_tagger;
   typedef struct packed {
      logic       sf;
      logic       ef;
      logic       es;
      logic       el;
      logic       eso;
      logic [11:0] x;
      logic [8:0]  y;
      logic [4:0]  r;
      logic [4:0]  g;
      logic [4:0]  b;
   } rec_t;

   logic clk;
   logic reset;
   int   tests_run = 0;
   int   failed    = 0;
   int   exp_fc    = 0;
   int   tready_low = 0;
   int   es_cnt = 0, el_cnt = 0, eso_cnt = 0;
   rec_t log_q[$];
   rec_t exp_q[$];

   pixel_stream_tagger_if #(.X_W(12), .Y_W(9)) bus ();

   pixel_stream_tagger #(.WIDTH(4), .HEIGHT(3), .X_W(12), .Y_W(9)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      rec_t v;
      if (bus.data_valid === 1'b1) begin
         v.sf = bus.start_frame; v.ef = bus.end_frame;
         v.es = bus.err_short;   v.el = bus.err_long;  v.eso = bus.err_sof;
         v.x  = bus.x; v.y = bus.y; v.r = bus.r; v.g = bus.g; v.b = bus.b;
         log_q.push_back(v);
      end
      if (bus.s_tready !== 1'b1) tready_low++;
      if (bus.err_short === 1'b1) es_cnt++;
      if (bus.err_long === 1'b1) el_cnt++;
      if (bus.err_sof === 1'b1) eso_cnt++;
   end

   // Pixel payload: r = column, g = row (g LSB set to prove it is dropped), b = column+row
   function automatic logic [15:0] enc(int x, int y);
      return {5'(x), 5'(y), 1'b1, 5'(x + y)};
   endfunction

   function automatic rec_t px(int x, int y, int dx, int dy, bit ef, bit es, bit el);
      rec_t v;
      v = '0;
      v.ef = ef; v.es = es; v.el = el;
      v.x = 12'(x); v.y = 9'(y);
      v.r = 5'(dx); v.g = 5'(dy); v.b = 5'(dx + dy);
      return v;
   endfunction

   function automatic rec_t sf_beat(bit eso);
      rec_t v;
      v = '0;
      v.sf = 1'b1;
      v.eso = eso;
      return v;
   endfunction

   function automatic string fmt(rec_t v);
      return $sformatf("sf=%0b ef=%0b es=%0b el=%0b eso=%0b xy=(%0d,%0d) rgb=%0d/%0d/%0d",
                       v.sf, v.ef, v.es, v.el, v.eso, v.x, v.y, v.r, v.g, v.b);
   endfunction

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         bus.s_tvalid = 1'b0;
         bus.s_tdata  = 16'($urandom);
         bus.s_tuser  = 1'($urandom);
         bus.s_tlast  = 1'($urandom);
      end
   endtask

   task automatic send(input logic [15:0] d, input logic u, input logic l);
      int guard;
      guard = 0;
      @(negedge clk);
      bus.s_tvalid = 1'b1; bus.s_tdata = d; bus.s_tuser = u; bus.s_tlast = l;
      while (bus.s_tready !== 1'b1 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 20) begin
         tests_run++; failed++;
         $display("FAIL send_timeout: s_tready=%b, required 1", bus.s_tready);
      end
   endtask

   // Sends columns x0..n-1 of row y, tlast on the final one, tuser on (0,0)
   task automatic send_row(input int y, input int x0, input int n, input int gap_max);
      for (int x = x0; x < n; x++) begin
         send(enc(x, y), (x == 0 && y == 0), (x == n - 1));
         if (gap_max > 0) idle($urandom_range(0, gap_max));
      end
   endtask

   task automatic push_clean_frame();
      exp_q.push_back(sf_beat(1'b0));
      for (int y = 0; y < 3; y++)
         for (int x = 0; x < 4; x++)
            exp_q.push_back(px(x, y, x, y, (x == 3 && y == 2), 1'b0, 1'b0));
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      tests_run++;
      if (bus.s_tready !== 1'b1) begin failed++; $display("FAIL reset_tready: got %b, required 1", bus.s_tready); end
      reset = 1'b0;
      @(negedge clk);
      tests_run++;
      if (bus.data_valid !== 1'b0 || bus.start_frame !== 1'b0 || bus.end_frame !== 1'b0) begin
         failed++; $display("FAIL reset_flags: got dv=%b sf=%b ef=%b, required 0 0 0", bus.data_valid, bus.start_frame, bus.end_frame);
      end
      tests_run++;
      if (bus.err_short !== 1'b0 || bus.err_long !== 1'b0 || bus.err_sof !== 1'b0) begin
         failed++; $display("FAIL reset_errs: got %b%b%b, required 000", bus.err_short, bus.err_long, bus.err_sof);
      end
      tests_run++;
      if (bus.x !== 12'd0 || bus.y !== 9'd0 || {bus.r, bus.g, bus.b} !== 15'd0) begin
         failed++; $display("FAIL reset_pixel: got (%0d,%0d) rgb=%h, required (0,0) 0", bus.x, bus.y, {bus.r, bus.g, bus.b});
      end
      tests_run++;
      if (bus.frame_count !== 16'd0) begin failed++; $display("FAIL reset_fc: got %0d, required 0", bus.frame_count); end
   endtask

   task automatic test_clean_frame();
      int base, low0;
      rec_t got;
      base = log_q.size(); low0 = tready_low;
      exp_q.delete(); push_clean_frame();
      for (int y = 0; y < 3; y++) send_row(y, 0, 4, 0);
      idle(4);
      exp_fc++;
      tests_run++;
      if (log_q.size() - base != exp_q.size()) begin failed++; $display("FAIL clean_count: got %0d beats, required %0d", log_q.size() - base, exp_q.size()); end
      foreach (exp_q[i]) begin
         got = (base + i < log_q.size()) ? log_q[base + i] : '0;
         tests_run++;
         if (got !== exp_q[i]) begin failed++; $display("FAIL clean_beat%0d: got %s, required %s", i, fmt(got), fmt(exp_q[i])); end
      end
      tests_run++;
      if (bus.frame_count !== 16'(exp_fc)) begin failed++; $display("FAIL clean_fc: got %0d, required %0d", bus.frame_count, exp_fc); end
      tests_run++;
      if (tready_low - low0 != 1) begin failed++; $display("FAIL clean_tready_low: got %0d cycles, required 1", tready_low - low0); end
   endtask

   task automatic test_colors();
      int base;
      rec_t got, e1, e2;
      base = log_q.size();
      e1 = '0; e1.r = 5'd31; e1.g = 5'd0;  e1.b = 5'd31;
      e2 = '0; e2.r = 5'd0;  e2.g = 5'd31; e2.b = 5'd0; e2.x = 12'd1;
      send(16'hF81F, 1'b1, 1'b0);
      send(16'h07E0, 1'b0, 1'b0);
      send_row(0, 2, 4, 0);
      send_row(1, 0, 4, 0);
      send_row(2, 0, 4, 0);
      idle(4);
      exp_fc++;
      got = (base + 1 < log_q.size()) ? log_q[base + 1] : '0;
      tests_run++;
      if (got !== e1) begin failed++; $display("FAIL color_F81F: got %s, required %s", fmt(got), fmt(e1)); end
      got = (base + 2 < log_q.size()) ? log_q[base + 2] : '0;
      tests_run++;
      if (got !== e2) begin failed++; $display("FAIL color_07E0: got %s, required %s", fmt(got), fmt(e2)); end
   endtask

   task automatic test_short_line();
      int base, es0;
      rec_t got;
      base = log_q.size(); es0 = es_cnt;
      exp_q.delete();
      exp_q.push_back(sf_beat(1'b0));
      for (int x = 0; x < 4; x++) exp_q.push_back(px(x, 0, x, 0, 1'b0, 1'b0, 1'b0));
      for (int x = 0; x < 3; x++) exp_q.push_back(px(x, 1, x, 1, 1'b0, (x == 2), 1'b0));
      for (int x = 0; x < 4; x++) exp_q.push_back(px(x, 2, x, 2, (x == 3), 1'b0, 1'b0));
      send_row(0, 0, 4, 0); send_row(1, 0, 3, 0); send_row(2, 0, 4, 0);
      idle(4);
      exp_fc++;
      tests_run++;
      if (log_q.size() - base != exp_q.size()) begin failed++; $display("FAIL short_count: got %0d beats, required %0d", log_q.size() - base, exp_q.size()); end
      foreach (exp_q[i]) begin
         got = (base + i < log_q.size()) ? log_q[base + i] : '0;
         tests_run++;
         if (got !== exp_q[i]) begin failed++; $display("FAIL short_beat%0d: got %s, required %s", i, fmt(got), fmt(exp_q[i])); end
      end
      tests_run++;
      if (es_cnt - es0 != 1) begin failed++; $display("FAIL short_err_count: got %0d pulses, required 1", es_cnt - es0); end
      tests_run++;
      if (bus.frame_count !== 16'(exp_fc)) begin failed++; $display("FAIL short_fc: got %0d, required %0d", bus.frame_count, exp_fc); end
   endtask

   task automatic test_long_line();
      int base, el0;
      rec_t got;
      base = log_q.size(); el0 = el_cnt;
      exp_q.delete();
      exp_q.push_back(sf_beat(1'b0));
      for (int x = 0; x < 4; x++) exp_q.push_back(px(x, 0, x, 0, 1'b0, 1'b0, 1'b0));
      for (int x = 0; x < 4; x++) exp_q.push_back(px(x, 1, x, 1, 1'b0, 1'b0, (x == 3)));
      for (int x = 0; x < 4; x++) exp_q.push_back(px(x, 2, x, 2, (x == 3), 1'b0, 1'b0));
      send_row(0, 0, 4, 0); send_row(1, 0, 6, 0); send_row(2, 0, 4, 0);
      idle(4);
      exp_fc++;
      tests_run++;
      if (log_q.size() - base != exp_q.size()) begin failed++; $display("FAIL long_count: got %0d beats, required %0d", log_q.size() - base, exp_q.size()); end
      foreach (exp_q[i]) begin
         got = (base + i < log_q.size()) ? log_q[base + i] : '0;
         tests_run++;
         if (got !== exp_q[i]) begin failed++; $display("FAIL long_beat%0d: got %s, required %s", i, fmt(got), fmt(exp_q[i])); end
      end
      tests_run++;
      if (el_cnt - el0 != 1) begin failed++; $display("FAIL long_err_count: got %0d pulses, required 1", el_cnt - el0); end
      tests_run++;
      if (bus.frame_count !== 16'(exp_fc)) begin failed++; $display("FAIL long_fc: got %0d, required %0d", bus.frame_count, exp_fc); end
   endtask

   task automatic test_sof_abort();
      int base, eso0;
      rec_t got;
      base = log_q.size(); eso0 = eso_cnt;
      exp_q.delete();
      exp_q.push_back(sf_beat(1'b0));
      for (int x = 0; x < 4; x++) exp_q.push_back(px(x, 0, x, 0, 1'b0, 1'b0, 1'b0));
      for (int x = 0; x < 2; x++) exp_q.push_back(px(x, 1, x, 1, 1'b0, 1'b0, 1'b0));
      exp_q.push_back(sf_beat(1'b1));
      exp_q.push_back(px(0, 0, 2, 1, 1'b0, 1'b0, 1'b0));
      for (int x = 1; x < 4; x++) exp_q.push_back(px(x, 0, x, 0, 1'b0, 1'b0, 1'b0));
      for (int x = 0; x < 4; x++) exp_q.push_back(px(x, 1, x, 1, 1'b0, 1'b0, 1'b0));
      for (int x = 0; x < 4; x++) exp_q.push_back(px(x, 2, x, 2, (x == 3), 1'b0, 1'b0));
      send_row(0, 0, 4, 0);
      send(enc(0, 1), 1'b0, 1'b0);
      send(enc(1, 1), 1'b0, 1'b0);
      send(enc(2, 1), 1'b1, 1'b0);
      idle(3);
      tests_run++;
      if (bus.frame_count !== 16'(exp_fc)) begin failed++; $display("FAIL sof_abort_fc_hold: got %0d, required %0d", bus.frame_count, exp_fc); end
      send_row(0, 1, 4, 0); send_row(1, 0, 4, 0); send_row(2, 0, 4, 0);
      idle(4);
      exp_fc++;
      tests_run++;
      if (log_q.size() - base != exp_q.size()) begin failed++; $display("FAIL sof_count: got %0d beats, required %0d", log_q.size() - base, exp_q.size()); end
      foreach (exp_q[i]) begin
         got = (base + i < log_q.size()) ? log_q[base + i] : '0;
         tests_run++;
         if (got !== exp_q[i]) begin failed++; $display("FAIL sof_beat%0d: got %s, required %s", i, fmt(got), fmt(exp_q[i])); end
      end
      tests_run++;
      if (eso_cnt - eso0 != 1) begin failed++; $display("FAIL sof_err_count: got %0d pulses, required 1", eso_cnt - eso0); end
   endtask

   task automatic test_sof_tlast();
      int base;
      rec_t got;
      base = log_q.size();
      exp_q.delete();
      exp_q.push_back(sf_beat(1'b0));
      exp_q.push_back(px(0, 0, 0, 0, 1'b0, 1'b1, 1'b0));
      for (int x = 0; x < 4; x++) exp_q.push_back(px(x, 1, x, 1, 1'b0, 1'b0, 1'b0));
      for (int x = 0; x < 4; x++) exp_q.push_back(px(x, 2, x, 2, (x == 3), 1'b0, 1'b0));
      send(enc(0, 0), 1'b1, 1'b1);
      send_row(1, 0, 4, 0); send_row(2, 0, 4, 0);
      idle(4);
      exp_fc++;
      tests_run++;
      if (log_q.size() - base != exp_q.size()) begin failed++; $display("FAIL sof_tlast_count: got %0d beats, required %0d", log_q.size() - base, exp_q.size()); end
      foreach (exp_q[i]) begin
         got = (base + i < log_q.size()) ? log_q[base + i] : '0;
         tests_run++;
         if (got !== exp_q[i]) begin failed++; $display("FAIL sof_tlast_beat%0d: got %s, required %s", i, fmt(got), fmt(exp_q[i])); end
      end
   endtask

   task automatic test_enable_off();
      int base;
      base = log_q.size();
      bus.enable = 1'b0;
      for (int y = 0; y < 3; y++) send_row(y, 0, 4, 0);
      idle(4);
      bus.enable = 1'b1;
      tests_run++;
      if (log_q.size() != base) begin failed++; $display("FAIL enable_off_beats: got %0d beats, required 0", log_q.size() - base); end
      tests_run++;
      if (bus.frame_count !== 16'(exp_fc)) begin failed++; $display("FAIL enable_off_fc: got %0d, required %0d", bus.frame_count, exp_fc); end
   endtask

   task automatic test_gaps();
      int base;
      rec_t got;
      base = log_q.size();
      exp_q.delete(); push_clean_frame();
      for (int y = 0; y < 3; y++) send_row(y, 0, 4, 3);
      idle(4);
      exp_fc++;
      tests_run++;
      if (log_q.size() - base != exp_q.size()) begin failed++; $display("FAIL gaps_count: got %0d beats, required %0d", log_q.size() - base, exp_q.size()); end
      foreach (exp_q[i]) begin
         got = (base + i < log_q.size()) ? log_q[base + i] : '0;
         tests_run++;
         if (got !== exp_q[i]) begin failed++; $display("FAIL gaps_beat%0d: got %s, required %s", i, fmt(got), fmt(exp_q[i])); end
      end
      tests_run++;
      if (bus.frame_count !== 16'(exp_fc)) begin failed++; $display("FAIL gaps_fc: got %0d, required %0d", bus.frame_count, exp_fc); end
   endtask

   task automatic test_back_to_back();
      int base, low0;
      rec_t got;
      base = log_q.size(); low0 = tready_low;
      exp_q.delete(); push_clean_frame(); push_clean_frame();
      for (int f = 0; f < 2; f++)
         for (int y = 0; y < 3; y++) send_row(y, 0, 4, 0);
      idle(4);
      exp_fc += 2;
      tests_run++;
      if (log_q.size() - base != exp_q.size()) begin failed++; $display("FAIL b2b_count: got %0d beats, required %0d", log_q.size() - base, exp_q.size()); end
      foreach (exp_q[i]) begin
         got = (base + i < log_q.size()) ? log_q[base + i] : '0;
         tests_run++;
         if (got !== exp_q[i]) begin failed++; $display("FAIL b2b_beat%0d: got %s, required %s", i, fmt(got), fmt(exp_q[i])); end
      end
      tests_run++;
      if (bus.frame_count !== 16'(exp_fc)) begin failed++; $display("FAIL b2b_fc: got %0d, required %0d", bus.frame_count, exp_fc); end
      tests_run++;
      if (tready_low - low0 != 2) begin failed++; $display("FAIL b2b_tready_low: got %0d cycles, required 2", tready_low - low0); end
   endtask

   task automatic test_reset_mid_frame();
      int base;
      rec_t got;
      send_row(0, 0, 3, 0);
      @(negedge clk);
      bus.s_tvalid = 1'b0;
      reset = 1'b1;
      #1;
      tests_run++;
      if (bus.s_tready !== 1'b1 || bus.data_valid !== 1'b0 || bus.frame_count !== 16'd0) begin
         failed++; $display("FAIL reset_mid: got tready=%b dv=%b fc=%0d, required 1 0 0", bus.s_tready, bus.data_valid, bus.frame_count);
      end
      @(negedge clk);
      reset = 1'b0;
      exp_fc = 0;
      base = log_q.size();
      exp_q.delete(); push_clean_frame();
      for (int y = 0; y < 3; y++) send_row(y, 0, 4, 0);
      idle(4);
      exp_fc++;
      got = (base + 12 < log_q.size()) ? log_q[base + 12] : '0;
      tests_run++;
      if (got !== exp_q[12]) begin failed++; $display("FAIL reset_mid_last: got %s, required %s", fmt(got), fmt(exp_q[12])); end
      tests_run++;
      if (bus.frame_count !== 16'(exp_fc)) begin failed++; $display("FAIL reset_mid_fc: got %0d, required %0d", bus.frame_count, exp_fc); end
   endtask

   initial begin
      bus.enable   = 1'b1;
      bus.s_tvalid = 1'b0;
      bus.s_tdata  = 16'h0000;
      bus.s_tuser  = 1'b0;
      bus.s_tlast  = 1'b0;
      reset        = 1'b1;
      test_reset();
      test_clean_frame();
      test_colors();
      test_short_line();
      test_long_line();
      test_sof_abort();
      test_sof_tlast();
      test_enable_off();
      test_gaps();
      test_back_to_back();
      test_reset_mid_frame();
      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end
endmodule

`default_nettype wire
